// File: rtl/prbs4_checker.sv
// Receive-side checker for the 4-bit PRBS (x^4+x^3+1, period 15) serial stream.
// Self-synchronises, locks, then counts bit errors against a free-running replica.
module prbs4_checker #(
    parameter int LOCK_CNT    = 8,
    parameter int WINDOW      = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    localparam logic [7:0] LP_LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LP_WIN_LAST  = 8'(WINDOW - 1);
    localparam logic [7:0] LP_UNLOCK    = 8'(UNLOCK_ERRS);

    state_t     r_state;
    logic [3:0] r_h;
    logic [1:0] r_fill;
    logic [7:0] r_match;
    logic [7:0] r_win_bits;
    logic [7:0] r_win_errs;

    logic       w_p;
    logic       w_bad;
    logic       w_match;
    logic       w_err_det;
    logic [7:0] w_errs_next;

    assign w_p         = r_h[0] ^ r_h[1];
    assign w_bad       = din ^ w_p;
    // An all-zero history predicts 0 forever, so it must never count as a match.
    assign w_match     = !w_bad && (r_h != '0);
    assign w_err_det   = din_valid && (r_state == ST_LOCKED) && w_bad;
    assign w_errs_next = r_win_errs + {7'd0, w_bad};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_SEED;
            r_h        <= '0;
            r_fill     <= '0;
            r_match    <= '0;
            r_win_bits <= '0;
            r_win_errs <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
        end else begin
            err <= w_err_det;

            if (clr_cnt)
                err_count <= w_err_det ? CNT_W'(1) : '0;
            else if (w_err_det && !(&err_count))
                err_count <= err_count + 1'b1;

            if (din_valid) begin
                case (r_state)
                    ST_SEED: begin
                        r_h <= {din, r_h[3:1]};
                        if (r_fill == 2'd3) begin
                            r_fill  <= '0;
                            r_match <= '0;
                            r_state <= ST_CHECK;
                        end else begin
                            r_fill <= r_fill + 2'd1;
                        end
                    end
                    ST_CHECK: begin
                        r_h <= {din, r_h[3:1]};
                        if (w_match) begin
                            if (r_match == LP_LOCK_LAST) begin
                                r_match    <= '0;
                                r_win_bits <= '0;
                                r_win_errs <= '0;
                                locked     <= 1'b1;
                                r_state    <= ST_LOCKED;
                            end else begin
                                r_match <= r_match + 8'd1;
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Replica feeds back its own prediction so line errors cannot corrupt it.
                        r_h <= {w_p, r_h[3:1]};
                        if (w_errs_next >= LP_UNLOCK) begin
                            r_fill  <= '0;
                            r_match <= '0;
                            locked  <= 1'b0;
                            r_state <= ST_SEED;
                        end else if (r_win_bits == LP_WIN_LAST) begin
                            r_win_bits <= '0;
                            r_win_errs <= {7'd0, w_bad};
                        end else begin
                            r_win_bits <= r_win_bits + 8'd1;
                            r_win_errs <= w_errs_next;
                        end
                    end
                    default: begin
                        r_state <= ST_SEED;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: scoreboarded vectors on a 16-bit and a 2-bit-counter instance
// driven with identical stimulus, plus direct reset checks.
module tb_prbs4_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       locked, err, locked2, err2;
    logic [15:0] err_count;
    logic [1:0]  err_count2;

    prbs4_checker dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_count(err_count)
    );

    prbs4_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked2), .err(err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    el;
        bit    ee;
        int    cnt;
        string tag;
    } exp_t;

    typedef struct {
        bit v;
        bit inv;
        bit clr;
        bit el;
        bit ee;
    } vec_t;

    exp_t sb[$];
    int   nerr = 0;
    int   nchk = 0;
    int   exp_cnt = 0;
    int   sp = 0;
    int   lb = 0;
    bit   cur_lk = 1'b0;
    bit   pat [0:14] = '{1,1,1,1,0,0,0,1,0,0,1,1,0,1,0};

    task automatic chk(string name, int act, int expv);
        nchk++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".locked"}, int'(locked), int'(e.el));
            chk({e.tag, ".err"}, int'(err), int'(e.ee));
            chk({e.tag, ".err_count"}, int'(err_count), e.cnt);
            chk({e.tag, ".locked2"}, int'(locked2), int'(e.el));
            chk({e.tag, ".err2"}, int'(err2), int'(e.ee));
            chk({e.tag, ".err_count2"}, int'(err_count2), (e.cnt > 3) ? 3 : e.cnt);
        end
    end

    task automatic step(bit v, bit d, bit c, bit el, bit ee, string tag);
        @(negedge clk);
        din_valid = v;
        din       = d;
        clr_cnt   = c;
        if (v) begin
            if (c) exp_cnt = ee ? 1 : 0;
            else if (ee) exp_cnt++;
        end
        sb.push_back('{el, ee, exp_cnt, tag});
    endtask

    task automatic vbit(bit v, bit inv, bit c, bit el, bit ee, string tag);
        bit d;
        if (v) begin
            if (cur_lk) lb++;
            d  = pat[sp] ^ inv;
            sp = (sp + 1) % 15;
        end else begin
            d = ~pat[sp];
        end
        step(v, d, c, el, ee, tag);
        if (el && !cur_lk) lb = 0;
        cur_lk = el;
    endtask

    task automatic pad_window();
        int n;
        n = (16 - (lb % 16)) % 16;
        for (int i = 0; i < n; i++) vbit(1, 0, 0, 1, 0, "pad");
    endtask

    task automatic drain();
        @(negedge clk);
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            chk("scoreboard_drain", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        drain();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.locked", int'(locked), 0);
        chk("reset.err", int'(err), 0);
        chk("reset.err_count", int'(err_count), 0);
        chk("reset.err_count2", int'(err_count2), 0);
        sp = 0; exp_cnt = 0; cur_lk = 0; lb = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        bit   inv;
        tbl[0] = '{v:0, inv:1, clr:0, el:1, ee:0};
        tbl[1] = '{v:1, inv:0, clr:1, el:1, ee:0};
        tbl[2] = '{v:1, inv:1, clr:0, el:1, ee:1};
        tbl[3] = '{v:1, inv:1, clr:1, el:1, ee:1};
        tbl[4] = '{v:0, inv:0, clr:0, el:1, ee:0};
        tbl[5] = '{v:1, inv:0, clr:0, el:1, ee:0};
        tbl[6] = '{v:1, inv:1, clr:0, el:1, ee:1};

        do_reset();

        // Clean stream: lock on the 12th valid edge, no errors.
        for (int i = 0; i < 100; i++) vbit(1, 0, 0, i >= 11, 0, "clean");

        // Single inverted bit: one err pulse, replica undisturbed.
        for (int i = 0; i < 20; i++) vbit(1, 0, 0, 1, 0, "pre1");
        vbit(1, 1, 0, 1, 1, "single");
        for (int i = 0; i < 30; i++) vbit(1, 0, 0, 1, 0, "post1");

        // Four errors in one window: unlock on the 4th, relock 12 bits later.
        vbit(1, 0, 1, 1, 0, "clr");
        pad_window();
        for (int off = 0; off < 14; off++) begin
            inv = (off == 1) || (off == 4) || (off == 8) || (off == 13);
            vbit(1, inv, 0, off != 13, inv, "unlock4");
        end
        for (int n = 1; n <= 12; n++) vbit(1, 0, n == 12, n == 12, 0, "relock");

        // Three errors per window for five windows: lock held, count reaches 15.
        for (int w = 0; w < 5; w++)
            for (int off = 0; off < 16; off++) begin
                inv = (off == 2) || (off == 7) || (off == 12);
                vbit(1, inv, 0, 1, inv, "win3");
            end

        // Valid-low hold and clr_cnt interactions, 2-bit counter already saturated.
        for (int i = 0; i < 7; i++)
            vbit(tbl[i].v, tbl[i].inv, tbl[i].clr, tbl[i].el, tbl[i].ee, $sformatf("tbl%0d", i));

        // Async reset mid-lock with a non-zero count.
        pad_window();
        vbit(1, 1, 0, 1, 1, "pre_rst");
        drain();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async.locked", int'(locked), 0);
        chk("async.err_count", int'(err_count), 0);
        chk("async.locked2", int'(locked2), 0);
        chk("async.err_count2", int'(err_count2), 0);
        @(negedge clk);
        rst = 1'b0;
        sp = 0; exp_cnt = 0; cur_lk = 0; lb = 0;

        // Stuck lines never lock.
        do_reset();
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 0, "stuck0");
        do_reset();
        for (int i = 0; i < 100; i++) step(1, 1, 0, 0, 0, "stuck1");

        // din_valid low every other cycle: lock still after 12 valid bits.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            vbit(0, 0, 0, cur_lk, 0, "gap_idle");
            vbit(1, 0, 0, i >= 11, 0, "gap_valid");
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
